csr_counter_unit: RTL



---
 rtl/csr_counter_unit_pkg.sv | 67 ++++++
 rtl/csr_counter_unit_counter.sv | 40 ++++
 rtl/csr_counter_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/csr_counter_unit_pkg.sv
// Shared CSR addresses, op encoding and address decode for the performance-counter block.
// Decode is shared by the read path and the optional write path (CSR_COUNTER_WRITE_EN).
package csr_counter_unit_pkg;

    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t CSR_CYCLE         = 12'hC00;
    localparam csr_addr_t CSR_TIME          = 12'hC01;
    localparam csr_addr_t CSR_INSTRET       = 12'hC02;
    localparam csr_addr_t CSR_HPM3          = 12'hC03;
    localparam csr_addr_t CSR_CYCLEH        = 12'hC80;
    localparam csr_addr_t CSR_TIMEH         = 12'hC81;
    localparam csr_addr_t CSR_INSTRETH      = 12'hC82;
    localparam csr_addr_t CSR_MCYCLE        = 12'hB00;
    localparam csr_addr_t CSR_MINSTRET      = 12'hB02;
    localparam csr_addr_t CSR_MHPM3         = 12'hB03;
    localparam csr_addr_t CSR_MCYCLEH       = 12'hB80;
    localparam csr_addr_t CSR_MCOUNTINHIBIT = 12'h320;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_t;

    // idx: 0 cycle, 1 instret, 2+i hpm[i]; zero: legal address that reads as 0
    typedef struct packed {
        logic       legal;
        logic       zero;
        logic       hi;
        logic       inh;
        logic [4:0] idx;
    } csr_dec_t;

    function automatic csr_dec_t csr_decode(input csr_addr_t addr, input int n_hpm,
                                            input logic hi_ok, input logic mach_ok);
        csr_dec_t   d;
        logic [6:0] blk;
        logic [4:0] off;
        logic       user;
        logic       mach;
        d    = '0;
        blk  = addr[11:5];
        off  = addr[4:0];
        user = (blk == 7'h60) || (hi_ok && blk == 7'h64);
        mach = mach_ok && ((blk == 7'h58) || (hi_ok && blk == 7'h5C));
        if (mach_ok && addr == CSR_MCOUNTINHIBIT) begin
            d.legal = 1'b1;
            d.inh   = 1'b1;
        end else if (user || mach) begin
            d.legal = 1'b1;
            d.hi    = addr[7];
            // time aliases cycle only in the user window; B01 has no counter
            if (off == 5'd0 || (off == 5'd1 && user))
                d.idx = 5'd0;
            else if (off == 5'd2)
                d.idx = 5'd1;
            else if (off >= 5'd3 && int'(off) < 3 + n_hpm)
                d.idx = off - 5'd1;
            else
                d.zero = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/csr_counter_unit_counter.sv
// One CNT_W performance counter: increments by inc unless inhibited; a half-word
// write replaces the selected XLEN half and takes priority over the increment.
module csr_counter
    import csr_counter_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc,
    input  logic             inhibit,
    input  logic             wr_en,
    input  logic             wr_hi,
    input  logic [XLEN-1:0]  wr_val,
    output logic [CNT_W-1:0] value
);
    localparam int W2 = 2 * XLEN;

    logic [W2-1:0] wide;

    always_comb begin
        wide = W2'(value);
        if (wr_hi)
            wide[W2-1:XLEN] = wr_val;
        else
            wide[XLEN-1:0] = wr_val;
    end

    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (wr_en)
            value <= wide[CNT_W-1:0];
        else if (!inhibit)
            value <= value + CNT_W'(inc);
    end

endmodule

// File: rtl/csr_counter_unit.sv
// Performance-counter CSR block: cycle/time/instret/hpm counters behind a registered read port.
// Define CSR_COUNTER_WRITE_EN for machine-mode write ports and mcountinhibit.
module csr_counter_unit
    import csr_counter_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int CNT_W    = 64,
    parameter int N_HPM    = 2,
    parameter int RETIRE_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RETIRE_W-1:0] retire_cnt,
    input  logic [N_HPM-1:0]    hpm_event,
    input  logic                csr_rd_en,
    input  csr_addr_t           csr_addr,
`ifdef CSR_COUNTER_WRITE_EN
    input  logic                csr_we,
    input  csr_op_t             csr_op,
    input  logic [XLEN-1:0]     csr_wdata,
`endif
    output logic                csr_rvalid,
    output logic [XLEN-1:0]     csr_rdata,
    output logic                csr_illegal
);
    localparam int   N_CNT = 2 + N_HPM;
    localparam int   W2    = 2 * XLEN;
    localparam logic HI_OK = (CNT_W > XLEN);
`ifdef CSR_COUNTER_WRITE_EN
    localparam logic MACH_OK = 1'b1;
`else
    localparam logic MACH_OK = 1'b0;
`endif

    logic [CNT_W-1:0] cnt_val [N_CNT];
    logic [N_CNT-1:0] cnt_inh;
    logic [N_CNT-1:0] cnt_we;
    logic [XLEN-1:0]  wr_val;
    logic [XLEN-1:0]  inh_q;
    csr_dec_t         dec;
    logic [W2-1:0]    rd_wide;
    logic [XLEN-1:0]  rd_half;

    assign dec = csr_decode(csr_addr, N_HPM, HI_OK, MACH_OK);

    always_comb begin
        rd_wide = '0;
        if (dec.inh)
            rd_wide = W2'(inh_q);
        else if (!dec.zero)
            for (int i = 0; i < N_CNT; i++)
                if (dec.idx == 5'(i))
                    rd_wide = W2'(cnt_val[i]);
        rd_half = dec.hi ? rd_wide[W2-1:XLEN] : rd_wide[XLEN-1:0];
    end

    csr_counter #(.XLEN(XLEN), .CNT_W(CNT_W), .INC_W(1)) u_cycle (
        .clk(clk), .rst(rst), .inc(1'b1), .inhibit(cnt_inh[0]),
        .wr_en(cnt_we[0]), .wr_hi(dec.hi), .wr_val(wr_val), .value(cnt_val[0])
    );

    csr_counter #(.XLEN(XLEN), .CNT_W(CNT_W), .INC_W(RETIRE_W)) u_instret (
        .clk(clk), .rst(rst), .inc(retire_cnt), .inhibit(cnt_inh[1]),
        .wr_en(cnt_we[1]), .wr_hi(dec.hi), .wr_val(wr_val), .value(cnt_val[1])
    );

    assign cnt_inh[0] = inh_q[0];
    assign cnt_inh[1] = inh_q[2];

    for (genvar i = 0; i < N_HPM; i++) begin : gen_hpm
        assign cnt_inh[2+i] = inh_q[3+i];
        csr_counter #(.XLEN(XLEN), .CNT_W(CNT_W), .INC_W(1)) u_hpm (
            .clk(clk), .rst(rst), .inc(hpm_event[i]), .inhibit(cnt_inh[2+i]),
            .wr_en(cnt_we[2+i]), .wr_hi(dec.hi), .wr_val(wr_val), .value(cnt_val[2+i])
        );
    end

`ifdef CSR_COUNTER_WRITE_EN
    // bit1 (time) and bits past the last hpm are hard-wired to 0
    localparam logic [XLEN-1:0] INH_MASK =
        XLEN'(((64'd1 << (3 + N_HPM)) - 64'd1) & ~64'd2);

    logic wr_ok;

    always_comb begin
        wr_val = rd_half;
        case (csr_op)
            CSR_OP_WRITE: wr_val = csr_wdata;
            CSR_OP_SET:   wr_val = rd_half | csr_wdata;
            CSR_OP_CLEAR: wr_val = rd_half & ~csr_wdata;
            default:      wr_val = rd_half;
        endcase
        wr_ok = csr_we && (csr_op != CSR_OP_NONE) && dec.legal && !dec.zero &&
                (dec.inh || csr_addr[11:8] == 4'hB);
    end

    always_comb begin
        cnt_we = '0;
        for (int i = 0; i < N_CNT; i++)
            cnt_we[i] = wr_ok && !dec.inh && (dec.idx == 5'(i));
    end

    always_ff @(posedge clk) begin
        if (rst)
            inh_q <= '0;
        else if (wr_ok && dec.inh)
            inh_q <= wr_val & INH_MASK;
    end
`else
    assign wr_val = '0;
    assign cnt_we = '0;
    assign inh_q  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            csr_rvalid  <= 1'b0;
            csr_rdata   <= '0;
            csr_illegal <= 1'b0;
        end else begin
            csr_rvalid  <= csr_rd_en;
            csr_rdata   <= (csr_rd_en && dec.legal) ? rd_half : '0;
            csr_illegal <= csr_rd_en && !dec.legal;
        end
    end

endmodule
